// File: rtl/qddc_pkg.sv
// Shared constants and helpers for the quadrature down-converter.
//   Word sizes: ISZ (ADC), WSZ (internal/tuner), FSZ (NCO word), OSZ (output)
//   CIC geometry: 3 stages, R=4 then R=32; CICSZx is full-precision width
package qddc_pkg;
  localparam int ISZ        = 14;
  localparam int WSZ        = 16;
  localparam int FSZ        = 31;
  localparam int OSZ        = 16;
  localparam int CIC_STAGES = 3;
  localparam int CIC1_R     = 4;
  localparam int CIC2_R     = 32;
  localparam int CIC1_GSZ   = $clog2(CIC1_R);                 // 2 bits growth/stage
  localparam int CIC2_GSZ   = $clog2(CIC2_R);                 // 5 bits growth/stage
  localparam int CICSZ1     = WSZ + CIC_STAGES * CIC1_GSZ;    // 22
  localparam int CICSZ2     = WSZ + CIC_STAGES * CIC2_GSZ;    // 31
  localparam int RCSZ       = 7;                              // rate counter, /128

  typedef struct packed {
    logic signed [WSZ-1:0] i;
    logic signed [WSZ-1:0] q;
  } wiq_t;

  // DC gain is exactly R^N = 2^(N*GSZ), so keeping the top WSZ bits is unity gain.
  function automatic logic signed [WSZ-1:0] trim1(input logic signed [CICSZ1-1:0] v);
    return v[CICSZ1-1 -: WSZ];
  endfunction

  function automatic logic signed [OSZ-1:0] trim2(input logic signed [CICSZ2-1:0] v);
    return v[CICSZ2-1 -: OSZ];
  endfunction
endpackage

// File: rtl/ci_co_tuner.sv
// Complex mixer: rotates (i,q) by -phase of a 64-point NCO, two-cycle latency.
//   clk, reset : clock, synchronous active-high reset (also used for bypass)
//   i_freq     : phase increment per clk, full circle = 2^FSZ
//   i_dir      : 1 flips the rotation direction
//   i_ns_en    : dither the phase below the LUT resolution (noise shaping)
//   i_i, i_q   : input sample
//   o_i, o_q   : rotated sample, saturated to WSZ bits
module ci_co_tuner import qddc_pkg::*; (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FSZ-1:0]        i_freq,
  input  logic                  i_dir,
  input  logic                  i_ns_en,
  input  logic signed [WSZ-1:0] i_i,
  input  logic signed [WSZ-1:0] i_q,
  output logic signed [WSZ-1:0] o_i,
  output logic signed [WSZ-1:0] o_q
);
  localparam int DSH = FSZ - 6 - 16;  // dither sits just below the 6 index bits

  // Quarter-wave cosine, Q15, k = 0..16 (5.625 deg steps).
  function automatic logic signed [15:0] qcos(input logic [4:0] k);
    case (k)
      5'd0:  qcos = 16'sd32767;  5'd1:  qcos = 16'sd32610;
      5'd2:  qcos = 16'sd32138;  5'd3:  qcos = 16'sd31357;
      5'd4:  qcos = 16'sd30274;  5'd5:  qcos = 16'sd28899;
      5'd6:  qcos = 16'sd27246;  5'd7:  qcos = 16'sd25330;
      5'd8:  qcos = 16'sd23170;  5'd9:  qcos = 16'sd20788;
      5'd10: qcos = 16'sd18205;  5'd11: qcos = 16'sd15447;
      5'd12: qcos = 16'sd12540;  5'd13: qcos = 16'sd9512;
      5'd14: qcos = 16'sd6393;   5'd15: qcos = 16'sd3212;
      default: qcos = 16'sd0;
    endcase
  endfunction

  function automatic logic signed [WSZ-1:0] sat(input logic signed [32:0] v);
    logic signed [17:0] s;
    s = v[32:15];
    if (s > 18'sd32767)       sat = 16'sd32767;
    else if (s < -18'sd32768) sat = -16'sd32768;
    else                      sat = s[15:0];
  endfunction

  logic [FSZ-1:0]        r_phase;
  logic [15:0]           r_lfsr;
  logic [FSZ-1:0]        w_dith;
  logic [5:0]            w_idx;
  logic [4:0]            w_k, w_kc;
  logic signed [15:0]    w_cos, w_sin;
  logic signed [15:0]    r_cos, r_sin;
  logic signed [WSZ-1:0] r_di, r_dq;
  logic signed [31:0]    w_ic, w_qs, w_qc, w_is;
  logic signed [32:0]    w_si, w_sq;
  logic signed [WSZ-1:0] r_oi, r_oq;

  assign w_dith = i_ns_en ? (FSZ'(r_lfsr) << DSH) : '0;
  assign w_idx  = 6'((r_phase + w_dith) >> (FSZ - 6));
  assign w_k    = {1'b0, w_idx[3:0]};
  assign w_kc   = 5'd16 - w_k;

  always_comb begin
    w_cos = '0;
    w_sin = '0;
    case (w_idx[5:4])
      2'd0: begin w_cos =  qcos(w_k);  w_sin =  qcos(w_kc); end
      2'd1: begin w_cos = -qcos(w_kc); w_sin =  qcos(w_k);  end
      2'd2: begin w_cos = -qcos(w_k);  w_sin = -qcos(w_kc); end
      default: begin w_cos = qcos(w_kc); w_sin = -qcos(w_k); end
    endcase
    if (i_dir) w_sin = -w_sin;
  end

  // (i + jq) * (cos - j sin)
  assign w_ic = r_di * r_cos;
  assign w_qs = r_dq * r_sin;
  assign w_qc = r_dq * r_cos;
  assign w_is = r_di * r_sin;
  assign w_si = {w_ic[31], w_ic} + {w_qs[31], w_qs};
  assign w_sq = {w_qc[31], w_qc} - {w_is[31], w_is};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= '0;
      r_lfsr  <= 16'hACE1;
      r_cos   <= '0;
      r_sin   <= '0;
      r_di    <= '0;
      r_dq    <= '0;
      r_oi    <= '0;
      r_oq    <= '0;
    end else begin
      r_phase <= r_phase + i_freq;
      r_lfsr  <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3]};
      r_cos   <= w_cos;
      r_sin   <= w_sin;
      r_di    <= i_i;
      r_dq    <= i_q;
      r_oi    <= sat(w_si);
      r_oq    <= sat(w_sq);
    end
  end

  assign o_i = r_oi;
  assign o_q = r_oq;
endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator, full-precision (bit growth NUM_STAGES*STG_GSZ).
//   clk, reset    : clock, synchronous active-high reset
//   in_rate       : integrators advance when high
//   out_rate      : combs and output register advance when high
//   in            : signed input sample, ISZ bits
//   out           : signed decimated output, ISZ+NUM_STAGES*STG_GSZ bits
// Integrators wrap modulo 2^W on purpose; the comb differences undo the wrap.
module cic_decimator #(
  parameter int NUM_STAGES = 3,
  parameter int STG_GSZ    = 2,
  parameter int ISZ        = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        in_rate,
  input  logic                                        out_rate,
  input  logic signed [ISZ-1:0]                       in,
  output logic signed [ISZ+NUM_STAGES*STG_GSZ-1:0]    out
);
  localparam int W = ISZ + NUM_STAGES * STG_GSZ;

  logic signed [W-1:0] r_integ [NUM_STAGES];
  logic signed [W-1:0] r_dly   [NUM_STAGES];
  logic signed [W-1:0] w_comb  [NUM_STAGES+1];
  logic signed [W-1:0] r_out;
  logic signed [W-1:0] w_in_ext;

  assign w_in_ext = {{(W-ISZ){in[ISZ-1]}}, in};

  // Comb chain is combinational off the last integrator; only the delays and
  // the output are registered, on the decimated edge.
  always_comb begin
    w_comb[0] = r_integ[NUM_STAGES-1];
    for (int k = 0; k < NUM_STAGES; k++)
      w_comb[k+1] = w_comb[k] - r_dly[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_integ[k] <= '0;
        r_dly[k]   <= '0;
      end
      r_out <= '0;
    end else begin
      if (in_rate) begin
        r_integ[0] <= r_integ[0] + w_in_ext;
        for (int k = 1; k < NUM_STAGES; k++)
          r_integ[k] <= r_integ[k] + r_integ[k-1];
      end
      if (out_rate) begin
        for (int k = 0; k < NUM_STAGES; k++)
          r_dly[k] <= w_comb[k];
        r_out <= w_comb[NUM_STAGES];
      end
    end
  end

  assign out = r_out;
endmodule

// File: rtl/qddc.sv
// Quadrature digital down-converter: ADC I/Q -> CIC /4 -> tuner -> CIC /32 -> baseband.
//   clk, reset           : ADC-rate clock, synchronous active-high reset
//   in_i, in_q           : 14-bit signed ADC samples, one per clk
//   lo_freq/lo_dir/lo_ns_en : NCO controls
//   iq_swap              : swap I and Q at the input
//   tuner_byp            : bypass mixer (mixer held in reset)
//   out_i, out_q         : 16-bit baseband, held between strobes
//   out_valid            : one-cycle strobe every 128 clks
module qddc import qddc_pkg::*; (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [ISZ-1:0] in_i,
  input  logic signed [ISZ-1:0] in_q,
  input  logic [FSZ-1:0]        lo_freq,
  input  logic                  lo_dir,
  input  logic                  lo_ns_en,
  input  logic                  iq_swap,
  input  logic                  tuner_byp,
  output logic signed [OSZ-1:0] out_i,
  output logic signed [OSZ-1:0] out_q,
  output logic                  out_valid
);
  logic [RCSZ-1:0]          r_rate_cnt;
  logic                     w_cic1_out_rate, w_cic2_out_rate;
  logic signed [ISZ-1:0]    r_d_i, r_d_q;
  logic signed [WSZ-1:0]    w_x_i, w_x_q;
  logic signed [CICSZ1-1:0] w_cic1_i, w_cic1_q;
  logic signed [CICSZ2-1:0] w_cic2_i, w_cic2_q;
  wiq_t                     w_c1t, w_tun, r_c2in;
  logic                     w_tun_rst;
  logic                     r_wrapped;
  logic signed [OSZ-1:0]    r_out_i, r_out_q;
  logic                     r_out_valid;

  assign w_cic1_out_rate = &r_rate_cnt[1:0];  // also the CIC2 input rate
  assign w_cic2_out_rate = &r_rate_cnt;
  assign w_x_i = {r_d_i, 2'b00};
  assign w_x_q = {r_d_q, 2'b00};
  assign w_tun_rst = reset | tuner_byp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rate_cnt <= '0;
      r_d_i      <= '0;
      r_d_q      <= '0;
    end else begin
      r_rate_cnt <= r_rate_cnt + 1'b1;
      r_d_i      <= iq_swap ? in_q : in_i;
      r_d_q      <= iq_swap ? in_i : in_q;
    end
  end

  cic_decimator #(.NUM_STAGES(CIC_STAGES), .STG_GSZ(CIC1_GSZ), .ISZ(WSZ)) u_cic1_i (
    .clk(clk), .reset(reset), .in_rate(1'b1), .out_rate(w_cic1_out_rate),
    .in(w_x_i), .out(w_cic1_i));
  cic_decimator #(.NUM_STAGES(CIC_STAGES), .STG_GSZ(CIC1_GSZ), .ISZ(WSZ)) u_cic1_q (
    .clk(clk), .reset(reset), .in_rate(1'b1), .out_rate(w_cic1_out_rate),
    .in(w_x_q), .out(w_cic1_q));

  assign w_c1t.i = trim1(w_cic1_i);
  assign w_c1t.q = trim1(w_cic1_q);

  ci_co_tuner u_tuner (
    .clk(clk), .reset(w_tun_rst), .i_freq(lo_freq), .i_dir(lo_dir), .i_ns_en(lo_ns_en),
    .i_i(w_c1t.i), .i_q(w_c1t.q), .o_i(w_tun.i), .o_q(w_tun.q));

  always_ff @(posedge clk) begin
    if (reset) r_c2in <= '0;
    else       r_c2in <= tuner_byp ? w_c1t : w_tun;
  end

  cic_decimator #(.NUM_STAGES(CIC_STAGES), .STG_GSZ(CIC2_GSZ), .ISZ(WSZ)) u_cic2_i (
    .clk(clk), .reset(reset), .in_rate(w_cic1_out_rate), .out_rate(w_cic2_out_rate),
    .in(r_c2in.i), .out(w_cic2_i));
  cic_decimator #(.NUM_STAGES(CIC_STAGES), .STG_GSZ(CIC2_GSZ), .ISZ(WSZ)) u_cic2_q (
    .clk(clk), .reset(reset), .in_rate(w_cic1_out_rate), .out_rate(w_cic2_out_rate),
    .in(r_c2in.q), .out(w_cic2_q));

  // CIC2 output lands on the 127->0 edge; it is copied out one edge later, so the
  // strobe sits at rate_cnt==1. r_wrapped suppresses the strobe before the first wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrapped   <= 1'b0;
      r_out_i     <= '0;
      r_out_q     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_cic2_out_rate) r_wrapped <= 1'b1;
      r_out_valid <= (r_rate_cnt == '0) && r_wrapped;
      if ((r_rate_cnt == '0) && r_wrapped) begin
        r_out_i <= trim2(w_cic2_i);
        r_out_q <= trim2(w_cic2_q);
      end
    end
  end

  assign out_i     = r_out_i;
  assign out_q     = r_out_q;
  assign out_valid = r_out_valid;
endmodule
